p_layer: RTL and testbench

// - Bit-permutation layer (pLayer) of the PRESENT-style SPN block cipher datapath.
// - Sits after the S-box layer in each round and moves bit i of the state to bit P(i).
// - Supports the forward permutation for encryption and the inverse permutation for decryption.
// - The output is registered with a valid flag, so each result appears one cycle after its input is accepted.

---
 rtl/crypto_pkg.sv | 19 +
 rtl/p_perm.sv | 18 +
 rtl/p_layer.sv | 51 +++++
 tb/tb_p_layer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared definitions for the SPN cipher datapath: default state width and
// the pLayer bit-index mapping functions used by the permutation network.
package crypto_pkg;

  localparam int STATE_W = 64;

  // Forward pLayer destination: bit i moves to (i*size/4) mod (size-1), top bit fixed.
  function automatic int p_index(input int i, input int size);
    if (i == size - 1) return size - 1;
    return (i * (size / 4)) % (size - 1);
  endfunction

  // Inverse destination: multiplying by 4 undoes multiplying by size/4 modulo size-1.
  function automatic int p_inv_index(input int j, input int size);
    if (j == size - 1) return size - 1;
    return (j * 4) % (size - 1);
  endfunction

endpackage

// File: rtl/p_perm.sv
// Combinational bit permutation: pure wiring, one output bit per input bit,
// routed by the forward or inverse pLayer index function.
module p_perm
  import crypto_pkg::*;
#(
  parameter int SIZE    = STATE_W,
  parameter bit INVERSE = 1'b0
) (
  input  logic [SIZE-1:0] orig_i,
  output logic [SIZE-1:0] perm_o
);

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    localparam int DST = INVERSE ? p_inv_index(i, SIZE) : p_index(i, SIZE);
    assign perm_o[DST] = orig_i[i];
  end

endmodule

// File: rtl/p_layer.sv
// PRESENT-style pLayer with selectable forward/inverse permutation and a
// registered output carrying a one-cycle valid flag.
module p_layer
  import crypto_pkg::*;
#(
  parameter int SIZE = STATE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            inverse,
  input  logic [SIZE-1:0] original,
  output logic            out_valid,
  output logic [SIZE-1:0] permuted
);

  if ((SIZE % 4) != 0 || SIZE < 8) begin : g_bad_size
    $error("p_layer: SIZE must be a multiple of 4 and >= 8");
  end

  logic [SIZE-1:0] fwd_w;
  logic [SIZE-1:0] inv_w;

  p_perm #(.SIZE(SIZE), .INVERSE(1'b0)) u_fwd (.orig_i(original), .perm_o(fwd_w));
  p_perm #(.SIZE(SIZE), .INVERSE(1'b1)) u_inv (.orig_i(original), .perm_o(inv_w));

  logic [SIZE-1:0] permuted_d, permuted_q;
  logic            out_valid_d, out_valid_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    permuted_d  = permuted_q;
    out_valid_d = in_valid;
    if (in_valid) permuted_d = inverse ? inv_w : fwd_w;
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and overrides in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      permuted_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      permuted_q  <= permuted_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign permuted  = permuted_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_p_layer.sv
// Self-checking bench for p_layer: directed vector table, round-trip,
// streaming, hold and mid-stream reset sequences.
module tb_p_layer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         inverse;
  logic [W-1:0] original;
  logic         out_valid;
  logic [W-1:0] permuted;

  int n_checks = 0;
  int n_pass   = 0;

  p_layer #(.SIZE(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .inverse  (inverse),
    .original (original),
    .out_valid(out_valid),
    .permuted (permuted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         inv;
    logic [W-1:0] orig;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one input on the falling edge, then sample the result on the next falling edge.
  task automatic apply(input logic inv, input logic [W-1:0] x, output logic v, output logic [W-1:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    inverse  = inv;
    original = x;
    @(negedge clk);
    in_valid = 1'b0;
    v = out_valid;
    y = permuted;
  endtask

  initial begin
    logic         v;
    logic [W-1:0] y, z, x;

    vecs[0]  = '{"fwd_bit0",      1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
    vecs[1]  = '{"fwd_nib0",      1'b0, 64'h0000_0000_0000_000F, 64'h0001_0001_0001_0001};
    vecs[2]  = '{"fwd_bit4",      1'b0, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0002};
    vecs[3]  = '{"fwd_bit63",     1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vecs[4]  = '{"fwd_ones",      1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5]  = '{"fwd_bit1",      1'b0, 64'h0000_0000_0000_0002, 64'h0000_0000_0001_0000};
    vecs[6]  = '{"fwd_bit62",     1'b0, 64'h4000_0000_0000_0000, 64'h0000_8000_0000_0000};
    vecs[7]  = '{"inv_spread",    1'b1, 64'h0001_0001_0001_0001, 64'h0000_0000_0000_000F};
    vecs[8]  = '{"inv_bit1",      1'b1, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0010};
    vecs[9]  = '{"inv_bit16",     1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0002};
    vecs[10] = '{"inv_bit63",     1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vecs[11] = '{"inv_zero",      1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    inverse  = 1'b0;
    original = '0;
    repeat (2) @(negedge clk);
    check("reset_permuted", permuted, '0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd1 - 64'd1);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      apply(vecs[k].inv, vecs[k].orig, v, y);
      check({vecs[k].name, "_valid"}, {63'd0, v}, 64'd1);
      check(vecs[k].name, y, vecs[k].exp);
    end

    x = 64'h0123_4567_89AB_CDEF;
    apply(1'b0, x, v, y);
    apply(1'b1, y, v, z);
    check("roundtrip_fixed", z, x);
    for (int r = 0; r < 1000; r++) begin
      x = {$urandom, $urandom};
      apply(1'b0, x, v, y);
      apply(1'b1, y, v, z);
      check("roundtrip_rand", z, x);
    end

    // Streaming: four back-to-back inputs, alternating direction.
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1;
      inverse  = vecs[s + 5].inv ^ s[0];
      original = (s[0]) ? vecs[7 + s / 2].orig : vecs[5 + s / 2].orig;
      inverse  = s[0];
      @(negedge clk);
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_data", permuted, (s[0]) ? vecs[7 + s / 2].exp : vecs[5 + s / 2].exp);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_valid", {63'd0, out_valid}, 64'd0);
    check("drop_hold", permuted, vecs[8].exp);
    @(negedge clk);
    check("hold_again", permuted, vecs[8].exp);

    // Reset wins over a simultaneous valid input.
    in_valid = 1'b1;
    inverse  = 1'b0;
    original = 64'hFFFF_FFFF_FFFF_FFFF;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst_permuted", permuted, '0);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    apply(1'b0, 64'h0000_0000_0000_000F, v, y);
    check("post_rst_valid", {63'd0, v}, 64'd1);
    check("post_rst_data", y, 64'h0001_0001_0001_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
